// File: rtl/carry_lookahead_adder_controller.sv
// Sequencing controller for an external carry-lookahead adder datapath.
// Clears the operand registers, loads A then B from the shared data_in bus,
// waits a fixed number of settle cycles, then captures {carry_out, sum} and
// holds it until the consumer acknowledges.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no operation in progress, carry_in forced low
// S_CLEAR | one-cycle clear pulse to both operand registers
// S_GET_A | accepting operand A (in_ready high, load_a follows in_valid)
// S_GET_B | accepting operand B (in_ready high, load_b follows in_valid)
// S_WAIT  | datapath settling, down-counter runs to zero then captures
// S_HOLD  | result_valid high, result frozen until result_ack

module carry_lookahead_adder_controller #(
  parameter int N           = 16,
  parameter int CALC_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cin_req,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N:0]   dp_sum,
  output logic         load_a,
  output logic         load_b,
  output logic         clr_a,
  output logic         clr_b,
  output logic         carry_in,
  output logic [N:0]   result,
  output logic         result_valid,
  input  logic         result_ack,
  output logic         busy
);

  // A single settle cycle still needs a one-bit counter that sits at zero.
  localparam int CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CALC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_GET_A = 3'd2,
    S_GET_B = 3'd3,
    S_WAIT  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [N:0]       result_next;
  logic             carry_in_next;

  // State, settle counter, captured result and latched carry-in registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      result   <= '0;
      carry_in <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      result   <= result_next;
      carry_in <= carry_in_next;
    end
  end

  // Next-state decode and Moore/Mealy datapath controls.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    result_next   = result;
    carry_in_next = carry_in;
    in_ready      = 1'b0;
    load_a        = 1'b0;
    load_b        = 1'b0;
    clr_a         = 1'b0;
    clr_b         = 1'b0;
    result_valid  = 1'b0;
    busy          = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next    = S_CLEAR;
          carry_in_next = cin_req;
        end
      end

      S_CLEAR: begin
        clr_a      = 1'b1;
        clr_b      = 1'b1;
        state_next = S_GET_A;
      end

      S_GET_A: begin
        in_ready = 1'b1;
        load_a   = in_valid;
        if (in_valid) begin
          state_next = S_GET_B;
        end
      end

      S_GET_B: begin
        in_ready = 1'b1;
        load_b   = in_valid;
        if (in_valid) begin
          state_next = S_WAIT;
          cnt_next   = CNT_LOAD;
        end
      end

      S_WAIT: begin
        if (cnt == '0) begin
          result_next = dp_sum;
          state_next  = S_HOLD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end

      S_HOLD: begin
        result_valid = 1'b1;
        // Ack with a simultaneous start chains straight into the next clear,
        // skipping IDLE so back-to-back sums lose no cycle.
        if (result_ack) begin
          if (start) begin
            state_next    = S_CLEAR;
            carry_in_next = cin_req;
          end else begin
            state_next    = S_IDLE;
            carry_in_next = 1'b0;
          end
        end
      end

      default: begin
        state_next    = S_IDLE;
        carry_in_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_carry_lookahead_adder_controller.sv
// Self-checking bench: datapath + operand source around the controller,
// a flag-based behavioural model compared every cycle, and directed
// operations with hand-computed sums and latencies.

module tb_carry_lookahead_adder_controller;

  localparam int N = 16;
  localparam int C = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin_req = 1'b0;
  logic         result_ack = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [N:0]   dp_sum;
  logic         load_a, load_b, clr_a, clr_b, carry_in;
  logic [N:0]   result;
  logic         result_valid;
  logic         busy;

  logic [N-1:0] data_in;
  logic [N-1:0] reg_a = '0;
  logic [N-1:0] reg_b = '0;
  logic [N-1:0] src_q[$];
  int           hold_cnt = 0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int k_start = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  carry_lookahead_adder_controller #(.N(N), .CALC_CYCLES(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cin_req(cin_req),
    .in_valid(in_valid), .in_ready(in_ready), .dp_sum(dp_sum),
    .load_a(load_a), .load_b(load_b), .clr_a(clr_a), .clr_b(clr_b),
    .carry_in(carry_in), .result(result), .result_valid(result_valid),
    .result_ack(result_ack), .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // External datapath: operand registers and the combinational adder.
  always @(posedge clk) begin
    if (clr_a) reg_a <= '0; else if (load_a) reg_a <= data_in;
    if (clr_b) reg_b <= '0; else if (load_b) reg_b <= data_in;
  end
  assign dp_sum = {1'b0, reg_a} + {1'b0, reg_b} + {{N{1'b0}}, carry_in};

  function automatic void update_src();
    in_valid = (src_q.size() > 0) && (hold_cnt == 0);
    data_in  = (src_q.size() > 0) ? src_q[0] : '0;
  endfunction

  // Operand source: pops on handshake, counts down a stall while ready.
  always @(posedge clk) begin
    bit hs;
    bit rdy;
    hs  = in_valid && in_ready;
    rdy = in_ready;
    #1;
    if (hs) void'(src_q.pop_front());
    else if (rdy && hold_cnt > 0) hold_cnt--;
    update_src();
  end

  // Behavioural model: progress flags for one operation.
  bit         m_act, m_clr, m_ha, m_hb, m_val, m_cin;
  int         m_wait;
  logic [N-1:0] m_a, m_b;
  logic [N:0] m_res;

  function automatic void new_op();
    m_act = 1'b1; m_clr = 1'b1; m_ha = 1'b0; m_hb = 1'b0; m_cin = cin_req;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_clr = 0; m_ha = 0; m_hb = 0; m_val = 0; m_cin = 0;
      m_wait = 0; m_res = '0;
    end else if (m_val) begin
      if (result_ack) begin
        m_val = 1'b0;
        if (start) new_op();
        else begin m_act = 1'b0; m_cin = 1'b0; end
      end
    end else if (!m_act) begin
      if (start) new_op();
    end else if (m_clr) begin
      m_clr = 1'b0; m_a = '0; m_b = '0;
    end else if (!m_ha) begin
      if (in_valid) begin m_ha = 1'b1; m_a = data_in; end
    end else if (!m_hb) begin
      if (in_valid) begin m_hb = 1'b1; m_b = data_in; m_wait = C - 1; end
    end else if (m_wait == 0) begin
      m_res = {1'b0, m_a} + {1'b0, m_b} + {{N{1'b0}}, m_cin};
      m_val = 1'b1;
    end else begin
      m_wait--;
    end
  end

  task automatic chk(input string name, input logic [N:0] act, input logic [N:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_ir;
      e_ir = m_act && !m_clr && !m_hb;
      chk("m_in_ready", in_ready, e_ir);
      chk("m_load_a", load_a, e_ir && !m_ha && in_valid);
      chk("m_load_b", load_b, e_ir && m_ha && in_valid);
      chk("m_clr_a", clr_a, m_act && m_clr);
      chk("m_clr_b", clr_b, m_act && m_clr);
      chk("m_busy", busy, m_act);
      chk("m_carry_in", carry_in, m_cin);
      chk("m_result_valid", result_valid, m_val);
      chk("m_result", result, m_res);
    end
  end

  task automatic begin_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input int h);
    src_q.push_back(a);
    src_q.push_back(b);
    hold_cnt = h;
    update_src();
    @(posedge clk); #1;
    k_start = cyc;
    start   = 1'b1;
    cin_req = cin;
  endtask

  task automatic finish_op(input logic [N:0] exp, input int exp_lat, input logic cin,
                           input bit spurious, input string name);
    int lat;
    int rel;
    lat = -1;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      @(posedge clk); #1;
      rel        = cyc - k_start;
      start      = spurious && (rel == 3 || rel == 4);
      result_ack = spurious && (rel == 2);
      cin_req    = ~cin;
      if (rel == 1) begin
        chk({name, "_clr_a"}, clr_a, 1'b1);
        chk({name, "_clr_b"}, clr_b, 1'b1);
      end
      if (result_valid) lat = rel;
      else chk({name, "_cin_run"}, carry_in, cin);
    end
    start = 1'b0;
    result_ack = 1'b0;
    chk_int({name, "_latency"}, lat, exp_lat);
    chk({name, "_result"}, result, exp);
    chk({name, "_cin_hold"}, carry_in, cin);
    repeat (2) begin
      @(posedge clk); #1;
      chk({name, "_held_result"}, result, exp);
      chk({name, "_held_valid"}, result_valid, 1'b1);
    end
  endtask

  task automatic ack_op(input bit start_next, input logic cin_next);
    result_ack = 1'b1;
    start      = start_next;
    cin_req    = cin_next;
    k_start    = cyc;
    if (!start_next) begin
      @(posedge clk); #1;
      result_ack = 1'b0;
      start      = 1'b0;
      chk("ack_valid_low", result_valid, 1'b0);
      chk("ack_idle", busy, 1'b0);
      chk("ack_cin_low", carry_in, 1'b0);
    end
  endtask

  initial begin
    update_src();
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_clr", clr_a, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_cin", carry_in, 1'b0);
    rst_n = 1'b1;

    begin_op(16'h1234, 16'h0FFF, 1'b0, 0);
    finish_op(17'h02233, 6, 1'b0, 1'b0, "basic");
    ack_op(1'b0, 1'b0);

    begin_op(16'hFFFF, 16'h0001, 1'b1, 0);
    finish_op(17'h10001, 6, 1'b1, 1'b0, "carry");
    ack_op(1'b0, 1'b0);

    begin_op(16'h00FF, 16'h0100, 1'b0, 3);
    finish_op(17'h001FF, 9, 1'b0, 1'b0, "stall");
    ack_op(1'b0, 1'b0);

    // Reset in the middle of WAIT aborts the sum.
    begin_op(16'hAAAA, 16'h5555, 1'b1, 0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", result_valid, 1'b0);
    chk("abort_result", result, '0);
    chk("abort_cin", carry_in, 1'b0);
    chk("abort_clr", clr_a, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    repeat (8) begin
      @(posedge clk); #1;
      chk("abort_no_valid", result_valid, 1'b0);
    end

    begin_op(16'h8000, 16'h8000, 1'b0, 0);
    finish_op(17'h10000, 6, 1'b0, 1'b0, "after_abort");
    ack_op(1'b0, 1'b0);

    begin_op(16'h0F0F, 16'h00F1, 1'b1, 0);
    finish_op(17'h01001, 6, 1'b1, 1'b0, "chain1");
    src_q.push_back(16'h0001);
    src_q.push_back(16'h0002);
    update_src();
    ack_op(1'b1, 1'b0);
    finish_op(17'h00003, 6, 1'b0, 1'b0, "chain2");
    ack_op(1'b0, 1'b0);

    begin_op(16'h1111, 16'h2222, 1'b0, 0);
    finish_op(17'h03333, 6, 1'b0, 1'b1, "spurious");
    ack_op(1'b0, 1'b0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("single_result_idle", busy, 1'b0);
      chk("single_result_valid", result_valid, 1'b0);
    end
    chk("kept_result", result, 17'h03333);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/carry_lookahead_adder_controller.md
CARRY_LOOKAHEAD_ADDER_CONTROLLER -- requirements
Module: carry_lookahead_adder_controller

Interface
REQ-001 SHALL have parameter N, default 16: operand width of the controlled adder datapath.
REQ-002 SHALL have parameter CALC_CYCLES, default 2: datapath settle cycles before result capture; legal range >= 1.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1: request a new addition.
REQ-006 SHALL have port cin_req  input  1: carry-in for the requested addition, sampled with start.
REQ-007 SHALL have port in_valid  input  1: operand on shared datapath data_in bus is valid.
REQ-008 SHALL have port in_ready  output  1: controller accepts an operand this cycle.
REQ-009 SHALL have port dp_sum  input  N+1: datapath data_out {carry_out, sum}.
REQ-010 SHALL have ports load_a, load_b, clr_a, clr_b, carry_in  output  1 each: datapath control.
REQ-011 SHALL have port result  output  N+1: captured sum.
REQ-012 SHALL have port result_valid  output  1: result holds a completed sum.
REQ-013 SHALL have port result_ack  input  1: consumer accepts result.
REQ-014 SHALL have port busy  output  1: high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CLEAR, GET_A, GET_B, WAIT, HOLD.
REQ-016 IDLE: on start=1 SHALL go to CLEAR and register cin_req into carry_in.
REQ-017 CLEAR: SHALL assert clr_a=clr_b=1 for exactly one cycle, then go to GET_A.
REQ-018 GET_A: SHALL drive in_ready=1 and load_a=in_valid combinationally; on in_valid=1 go to GET_B, else stay.
REQ-019 GET_B: SHALL drive in_ready=1 and load_b=in_valid; on in_valid=1 go to WAIT and load counter with CALC_CYCLES-1.
REQ-020 WAIT: counter SHALL decrement each cycle; in the cycle it equals 0, result SHALL capture dp_sum at that edge and FSM go to HOLD.
REQ-021 HOLD: result_valid=1 and result SHALL stay stable until result_ack=1; then go to IDLE.
REQ-022 HOLD with result_ack=1 and start=1 in the same cycle SHALL go directly to CLEAR and latch the new cin_req.
REQ-023 start SHALL be ignored in CLEAR, GET_A, GET_B, WAIT, and in HOLD without result_ack.
REQ-024 result_ack outside HOLD SHALL be ignored.
REQ-025 load_a, load_b, in_ready SHALL be 0 outside GET_A/GET_B; load_a and load_b SHALL never be high in the same cycle.
REQ-026 carry_in SHALL remain constant from CLEAR through HOLD and be 0 in IDLE.
REQ-027 result SHALL be dp_sum unmodified, N+1 bits, bit N = carry out; no truncation or saturation.
REQ-028 Latency with continuous in_valid: start sampled in cycle 0 -> result_valid high from cycle 4+CALC_CYCLES.
REQ-029 result SHALL keep its last value after ack until the next capture.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force IDLE, counter 0, result 0, result_valid 0, carry_in 0, busy 0, and all datapath control outputs 0, from any state including mid-operation.
REQ-031 An operation aborted by reset SHALL never assert result_valid; the next operation SHALL begin with CLEAR.

Verification
REQ-032 N=16, CALC_CYCLES=2: start, cin_req=0, A=0x1234, B=0x0FFF, in_valid continuous -> result=0x02233, result_valid rises cycle 6, held until ack.
REQ-033 A=0xFFFF, B=0x0001, cin_req=1 -> result=0x10001, carry_in=1 from CLEAR to HOLD.
REQ-034 in_valid low for 3 cycles in GET_A -> no load_a pulse, state held; result_valid delayed by exactly 3 cycles.
REQ-035 rst_n=0 for one cycle during WAIT -> next cycle all outputs 0, state IDLE, no result_valid.
REQ-036 result_ack=1 with start=1 in HOLD -> clr_a/clr_b next cycle; second sum 0x0001+0x0002 gives 0x00003.
REQ-037 start pulsed in GET_B and WAIT -> ignored; exactly one result produced.
